// File: rtl/sipo_pkg.sv
// Shared types and sizing helpers for the SIPO lane bank.
package sipo_pkg;

    typedef enum logic {
        FILL = 1'b0,
        PEND = 1'b1
    } state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r++;
        end
        return r;
    endfunction

    // Counter width, never narrower than one bit.
    function automatic int cnt_w(input int width);
        return (clog2(width) < 1) ? 1 : clog2(width);
    endfunction

endpackage

// File: rtl/sipo_skew_line.sv
// Valid+data delay line: one capture register plus DEPTH extra stages.
// Data outside a valid slot is held at zero.
module sipo_skew_line #(
    parameter int DEPTH = 0,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [DEPTH:0]            vld_q, vld_d;
    logic [DEPTH:0][WIDTH-1:0] dat_q, dat_d;

    always_comb begin
        vld_d = '0;
        dat_d = '0;
        if (!clr) begin
            vld_d[0] = in_valid;
            dat_d[0] = in_valid ? in_data : '0;
            for (int s = 1; s <= DEPTH; s++) begin
                vld_d[s] = vld_q[s-1];
                dat_d[s] = dat_q[s-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign out_valid = vld_q[DEPTH];
    assign out_data  = dat_q[DEPTH];

endmodule

// File: rtl/sipo_lane_bank.sv
// Multi-lane serial-in/parallel-out bank with a double-buffered output word.
// Define SIPO_SKEW_EN to add the per-lane diagonal skew outputs.
module sipo_lane_bank
    import sipo_pkg::*;
#(
    parameter int LANES     = 8,
    parameter int WIDTH     = 16,
    parameter int MSB_FIRST = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES-1:0]       ser_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] par_out,
    output logic [LANES-1:0]       skew_valid,
    output logic [LANES*WIDTH-1:0] skew_out
);

    localparam int              CNT_W = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_e                        state_q, state_d;
    logic [CNT_W-1:0]              bit_cnt_q, bit_cnt_d;
    logic [LANES-1:0][WIDTH-1:0]   shift_q, shift_d, shifted;
    logic [LANES-1:0][WIDTH-1:0]   par_q, par_d;
    logic                          out_valid_q, out_valid_d;
    logic                          accept, xfer;

    assign in_ready  = (state_q == FILL);
    assign accept    = in_valid & in_ready;
    assign xfer      = out_valid_q & out_ready;
    assign out_valid = out_valid_q;
    assign par_out   = par_q;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        if (MSB_FIRST != 0) begin : g_msb
            assign shifted[i] = (shift_q[i] << 1) | WIDTH'(ser_in[i]);
        end else begin : g_lsb
            assign shifted[i] = (shift_q[i] >> 1) | (WIDTH'(ser_in[i]) << (WIDTH - 1));
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_d       = par_q;
        out_valid_d = out_valid_q & ~xfer;
        if (clr) begin
            state_d     = FILL;
            bit_cnt_d   = '0;
            shift_d     = '0;
            par_d       = '0;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    if (accept) begin
                        shift_d = shifted;
                        if (bit_cnt_q == LAST) begin
                            bit_cnt_d = '0;
                            // Output slot frees up this cycle or is empty: hand over directly.
                            if (!out_valid_q || xfer) begin
                                par_d       = shifted;
                                out_valid_d = 1'b1;
                            end else begin
                                state_d = PEND;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end
                PEND: begin
                    if (xfer) begin
                        par_d       = shift_q;
                        out_valid_d = 1'b1;
                        state_d     = FILL;
                    end
                end
                default: state_d = FILL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef SIPO_SKEW_EN
    for (genvar i = 0; i < LANES; i++) begin : g_skew
        sipo_skew_line #(
            .DEPTH (i),
            .WIDTH (WIDTH)
        ) u_line (
            .clk       (clk),
            .rst_n     (rst_n),
            .clr       (clr),
            .in_valid  (xfer),
            .in_data   (par_q[i]),
            .out_valid (skew_valid[i]),
            .out_data  (skew_out[i*WIDTH +: WIDTH])
        );
    end
`else
    assign skew_valid = '0;
    assign skew_out   = '0;
`endif

endmodule

// File: tb/tb_sipo_lane_bank.sv
// Randomized bench for sipo_lane_bank against a queue-based word model.
module tb_sipo_lane_bank;

    localparam int LANES = 4;
    localparam int WIDTH = 8;
    localparam int PW    = LANES * WIDTH;

    logic             clk = 1'b0;
    logic             rst_n, clr, in_valid, in_ready, out_valid, out_ready;
    logic [LANES-1:0] ser_in, skew_valid;
    logic [PW-1:0]    par_out, skew_out;

    int errs   = 0;
    int checks = 0;

    sipo_lane_bank #(.LANES(LANES), .WIDTH(WIDTH), .MSB_FIRST(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ser_in     (ser_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .par_out    (par_out),
        .skew_valid (skew_valid),
        .skew_out   (skew_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: words assembled from bit counts; completed words wait in a
    // two-entry queue (output slot + full shift register).
    typedef struct {
        int               due;
        int               lane;
        logic [WIDTH-1:0] data;
    } skev_t;

    int            m_bits;
    int            m_acc [LANES];
    logic [PW-1:0] m_q [$];
    skev_t         m_sk [$];
    int            cyc    = 0;
    int            n_xfer = 0;

    task automatic m_reset();
        m_bits = 0;
        for (int k = 0; k < LANES; k++) m_acc[k] = 0;
        m_q.delete();
        m_sk.delete();
    endtask

    task automatic check_outs();
        logic [LANES-1:0] ev;
        logic [PW-1:0]    eo;
        ev = '0;
        eo = '0;
        chk("in_ready", in_ready, m_q.size() < 2);
        chk("out_valid", out_valid, m_q.size() > 0);
        if (m_q.size() > 0) chk("par_out", par_out, m_q[0]);
`ifdef SIPO_SKEW_EN
        foreach (m_sk[i]) begin
            if (m_sk[i].due == cyc) begin
                ev[m_sk[i].lane] = 1'b1;
                eo[m_sk[i].lane*WIDTH +: WIDTH] = m_sk[i].data;
            end
        end
`endif
        chk("skew_valid", skew_valid, ev);
        chk("skew_out", skew_out, eo);
    endtask

    task automatic step(input logic iv, input logic [LANES-1:0] b, input logic ordy, input logic c);
        logic          xf, acc;
        logic [PW-1:0] w;
        check_outs();
        in_valid  = iv;
        ser_in    = b;
        out_ready = ordy;
        clr       = c;
        xf  = (m_q.size() > 0) && ordy;
        acc = (m_q.size() < 2) && iv;
        if (xf) n_xfer++;
        if (c) begin
            m_reset();
        end else begin
            if (xf) begin
                for (int i = 0; i < LANES; i++)
                    m_sk.push_back('{cyc + 1 + i, i, m_q[0][i*WIDTH +: WIDTH]});
                void'(m_q.pop_front());
            end
            if (acc) begin
                for (int k = 0; k < LANES; k++)
                    m_acc[k] = ((m_acc[k] << 1) | int'(b[k])) & ((1 << WIDTH) - 1);
                m_bits++;
                if (m_bits == WIDTH) begin
                    w = '0;
                    for (int k = 0; k < LANES; k++) w[k*WIDTH +: WIDTH] = m_acc[k][WIDTH-1:0];
                    m_q.push_back(w);
                    m_bits = 0;
                end
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        for (int i = m_sk.size() - 1; i >= 0; i--)
            if (m_sk[i].due < cyc) m_sk.delete(i);
    endtask

    task automatic async_rst(input string tag);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        m_reset();
        chk({tag, "_rdy"}, in_ready, 1'b1);
        chk({tag, "_vld"}, out_valid, 1'b0);
        chk({tag, "_par"}, par_out, '0);
        chk({tag, "_skv"}, skew_valid, '0);
        chk({tag, "_sko"}, skew_out, '0);
        @(negedge clk);
        cyc++;
        rst_n = 1'b1;
    endtask

    logic [PW-1:0]    w2;
    logic [LANES-1:0] b;
    int               n_stall;

    initial begin
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; ser_in = '0;
        m_reset();
        @(negedge clk);
        chk("rst_rdy", in_ready, 1'b1);
        chk("rst_vld", out_valid, 1'b0);
        chk("rst_par", par_out, '0);
        chk("rst_skv", skew_valid, '0);
        rst_n = 1'b1;

        // 1: lane k streams 0xA0+k MSB-first
        for (int j = 0; j < WIDTH; j++) begin
            for (int k = 0; k < LANES; k++) b[k] = ((8'hA0 + k) >> (WIDTH - 1 - j)) & 1;
            step(1'b1, b, 1'b1, 1'b0);
        end
        chk("t1_vld", out_valid, 1'b1);
        chk("t1_word", par_out, 32'hA3A2A1A0);

        // 2: backpressure into PEND
        step(1'b0, '0, 1'b1, 1'b0);
        for (int j = 0; j < 2 * WIDTH; j++) step(1'b1, LANES'($urandom), 1'b0, 1'b0);
        chk("t2_pend_rdy", in_ready, 1'b0);
        w2 = m_q[1];
        step(1'b1, LANES'($urandom), 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("t2_rdy", in_ready, 1'b1);
        chk("t2_word2", par_out, w2);

        // 3: sustained streaming
        step(1'b0, '0, 1'b1, 1'b1);
        n_xfer  = 0;
        n_stall = 0;
        for (int j = 0; j < 80; j++) begin
            if (!in_ready) n_stall++;
            step(1'b1, LANES'($urandom), 1'b1, 1'b0);
        end
        step(1'b0, '0, 1'b1, 1'b0);
        chk("t3_xfers", n_xfer, 10);
        chk("t3_stalls", n_stall, 0);

        // 4: clr mid-word
        for (int j = 0; j < 5; j++) step(1'b1, LANES'($urandom), 1'b1, 1'b0);
        step(1'b1, LANES'($urandom), 1'b1, 1'b1);
        for (int j = 0; j < WIDTH; j++) begin
            b = {LANES{1'((8'h5A >> (WIDTH - 1 - j)) & 1)}};
            step(1'b1, b, 1'b0, 1'b0);
        end
        chk("t4_vld", out_valid, 1'b1);
        chk("t4_word", par_out, 32'h5A5A5A5A);

        // 5: async reset mid-word and mid-PEND
        for (int j = 0; j < 3; j++) step(1'b1, LANES'($urandom), 1'b0, 1'b0);
        async_rst("t5a");
        for (int j = 0; j < 2 * WIDTH; j++) step(1'b1, LANES'($urandom), 1'b0, 1'b0);
        chk("t5_pend", in_ready, 1'b0);
        async_rst("t5b");

        // 6: random traffic
        for (int j = 0; j < 600; j++)
            step(($urandom % 4) != 0, LANES'($urandom), ($urandom % 3) != 0, ($urandom % 40) == 0);
        for (int j = 0; j < 2 * LANES; j++) step(1'b0, '0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
